// File: rtl/pipelined_adder_if.sv
// Operand/result handshake bundle for pipelined_adder.
//
// Signals (slave = the adder, master = the producer/consumer around it):
//   in_valid  : operands present this cycle                 (master -> slave)
//   in_ready  : adder accepts operands this cycle           (slave -> master)
//   a, b      : WIDTH-bit operands                          (master -> slave)
//   cin       : carry-in, ignored when sub=1                (master -> slave)
//   sub       : 0 = a+b+cin, 1 = a-b                        (master -> slave)
//   out_valid : result present                              (slave -> master)
//   out_ready : consumer accepts the result                 (master -> slave)
//   sum       : WIDTH-bit result                            (slave -> master)
//   cout      : carry out of the MSB (sub: 1 = no borrow)   (slave -> master)
//   ovf       : two's-complement signed overflow            (slave -> master)
//
// WIDTH must match the WIDTH of the pipelined_adder instance using it.

interface pipelined_adder_if #(
    parameter int unsigned WIDTH = 16
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid,
        input  in_ready,
        output a,
        output b,
        output cin,
        output sub,
        input  out_valid,
        output out_ready,
        input  sum,
        input  cout,
        input  ovf
    );

    modport slave (
        input  in_valid,
        output in_ready,
        input  a,
        input  b,
        input  cin,
        input  sub,
        output out_valid,
        input  out_ready,
        output sum,
        output cout,
        output ovf
    );

endinterface

// File: rtl/pipelined_adder.sv
// Carry-pipelined adder/subtractor: each stage adds one CHUNK-bit slice (LSB
// slice first) using the carry registered by the previous stage. Operand bits
// not yet consumed travel down the pipe with the partial sum, so a result
// appears STAGES = WIDTH/CHUNK cycles after acceptance, one op per cycle.
// The whole pipe freezes while a result is waiting on the consumer.
//
// Ports:
//   clk : sole clock, rising edge
//   rst : synchronous, active-high reset; drops all in-flight operations
//   bus : pipelined_adder_if.slave (in_valid/in_ready/a/b/cin/sub in,
//         out_valid/out_ready/sum/cout/ovf out)
//
// Parameters:
//   WIDTH : operand/result width, a multiple of CHUNK in 4..64
//   CHUNK : bits summed per stage
//
// Build option:
//   PIPELINED_ADDER_SAT_EN : when defined, sum saturates on signed overflow
//                            (0111..1 positive, 1000..0 negative); ovf and
//                            cout are unaffected. Otherwise sum wraps.

module pipelined_adder #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 4
) (
    input logic              clk,
    input logic              rst,
    pipelined_adder_if.slave bus
);

    localparam int unsigned STAGES = WIDTH / CHUNK;

    logic stall;
    logic accept;

    assign stall        = g_stage[STAGES-1].v_q && !bus.out_ready;
    assign accept       = bus.in_valid && !stall;
    assign bus.in_ready = !stall;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        // Operand bits still to be added when entering this stage, and sum
        // bits finished once this stage has run.
        localparam int unsigned REM  = WIDTH - k * CHUNK;
        localparam int unsigned DONE = (k + 1) * CHUNK;

        logic [REM-1:0]  a_in;
        logic [REM-1:0]  b_in;
        logic            c_in;
        logic            v_in;
        logic [CHUNK:0]  part;
        logic [DONE-1:0] s_in;
        logic [DONE-1:0] s_next;

        logic            v_q;
        logic            c_q;
        logic [DONE-1:0] s_q;

        assign part = {1'b0, a_in[CHUNK-1:0]} + {1'b0, b_in[CHUNK-1:0]}
                    + {{CHUNK{1'b0}}, c_in};

        if (k == 0) begin : g_head
            // Subtraction is a + ~b + 1; cin is ignored in that case.
            assign a_in = bus.a;
            assign b_in = bus.sub ? ~bus.b : bus.b;
            assign c_in = bus.sub ? 1'b1 : bus.cin;
            assign v_in = accept;
            assign s_in = part[CHUNK-1:0];
        end else begin : g_body
            assign a_in = g_stage[k-1].g_rem.a_q;
            assign b_in = g_stage[k-1].g_rem.b_q;
            assign c_in = g_stage[k-1].c_q;
            assign v_in = g_stage[k-1].v_q;
            assign s_in = {part[CHUNK-1:0], g_stage[k-1].s_q};
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                v_q <= 1'b0;
                c_q <= 1'b0;
                s_q <= '0;
            end else if (!stall) begin
                v_q <= v_in;
                c_q <= part[CHUNK];
                s_q <= s_next;
            end
        end

        if (k < STAGES - 1) begin : g_rem
            logic [REM-CHUNK-1:0] a_q;
            logic [REM-CHUNK-1:0] b_q;

            assign s_next = s_in;

            always_ff @(posedge clk) begin
                if (rst) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (!stall) begin
                    a_q <= a_in[REM-1:CHUNK];
                    b_q <= b_in[REM-1:CHUNK];
                end
            end
        end else begin : g_tail
            logic ovf_d;
            logic ovf_q;

            // Top slice holds the sign bits of a and the effective addend.
            assign ovf_d = (a_in[CHUNK-1] == b_in[CHUNK-1])
                        && (part[CHUNK-1] != a_in[CHUNK-1]);

`ifdef PIPELINED_ADDER_SAT_EN
            // Overflow direction follows the sign of a (both operands agree).
            always_comb begin
                s_next = s_in;
                if (ovf_d) begin
                    s_next = {a_in[CHUNK-1], {(DONE-1){~a_in[CHUNK-1]}}};
                end
            end
`else
            assign s_next = s_in;
`endif

            always_ff @(posedge clk) begin
                if (rst) begin
                    ovf_q <= 1'b0;
                end else if (!stall) begin
                    ovf_q <= ovf_d;
                end
            end
        end
    end

    assign bus.out_valid = g_stage[STAGES-1].v_q;
    assign bus.sum       = g_stage[STAGES-1].s_q;
    assign bus.cout      = g_stage[STAGES-1].c_q;
    assign bus.ovf       = g_stage[STAGES-1].g_tail.ovf_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder (WIDTH=16, CHUNK=4). A negedge
// monitor pushes model results on every input transfer and checks every
// presented result against the head of the queue; the initial block walks
// through directed steps (reset, latency, corner sums, stall, mid-flight reset).

module tb_pipelined_adder;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned CHUNK = 4;

    typedef struct packed {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } res_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    pipelined_adder_if #(.WIDTH(WIDTH)) bus ();

    pipelined_adder #(
        .WIDTH(WIDTH),
        .CHUNK(CHUNK)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int   checks = 0;
    int   errors = 0;
    int   n_out  = 0;
    res_t q[$];
    res_t head;

    function automatic res_t model(input logic [15:0] a, input logic [15:0] b,
                                   input logic cin, input logic sub);
        int          ra;
        int          rb;
        int          r;
        logic [16:0] u;
        res_t        m;
        ra = int'($signed(a));
        rb = int'($signed(b));
        if (sub) begin
            r      = ra - rb;
            m.sum  = a - b;
            m.cout = (a >= b);
        end else begin
            r      = ra + rb + int'(cin);
            u      = {1'b0, a} + {1'b0, b} + {16'b0, cin};
            m.sum  = u[15:0];
            m.cout = u[16];
        end
        m.ovf = (r > 32767) || (r < -32768);
`ifdef PIPELINED_ADDER_SAT_EN
        if (m.ovf) m.sum = (r > 0) ? 16'h7FFF : 16'h8000;
`endif
        return m;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: inputs are stable by the falling edge, so transfers that
    // happen at the next rising edge are decided here.
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
        end else begin
            if (bus.out_valid) begin
                if (q.size() == 0) begin
                    check("unexpected_result", {31'b0, bus.out_valid}, 32'd0);
                end else begin
                    head = q[0];
                    check("sb_sum", {16'b0, bus.sum}, {16'b0, head.sum});
                    check("sb_cout", {31'b0, bus.cout}, {31'b0, head.cout});
                    check("sb_ovf", {31'b0, bus.ovf}, {31'b0, head.ovf});
                    if (bus.out_ready) begin
                        void'(q.pop_front());
                        n_out++;
                    end
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                q.push_back(model(bus.a, bus.b, bus.cin, bus.sub));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One isolated op: checks it emerges exactly four cycles after acceptance.
    task automatic send_lat(input logic [15:0] a, input logic [15:0] b, input logic cin,
                            input logic sub, input logic [15:0] exp_sum,
                            input logic exp_cout, input logic exp_ovf, input string tag);
        bus.in_valid = 1'b1;
        bus.a        = a;
        bus.b        = b;
        bus.cin      = cin;
        bus.sub      = sub;
        tick();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check({tag, "_early"}, {31'b0, bus.out_valid}, 32'd0);
            tick();
        end
        check({tag, "_valid"}, {31'b0, bus.out_valid}, 32'd1);
        check({tag, "_sum"}, {16'b0, bus.sum}, {16'b0, exp_sum});
        check({tag, "_cout"}, {31'b0, bus.cout}, {31'b0, exp_cout});
        check({tag, "_ovf"}, {31'b0, bus.ovf}, {31'b0, exp_ovf});
        tick();
    endtask

    logic [15:0] sa [8];
    logic [15:0] sb [8];
    logic        sc [8];
    logic        ss [8];
    int          sent;
    int          base;
    logic        acc;
    res_t        m;

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.cin       = 1'b0;
        bus.sub       = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        check("rst_sum", {16'b0, bus.sum}, 32'd0);
        check("rst_cout", {31'b0, bus.cout}, 32'd0);
        check("rst_ovf", {31'b0, bus.ovf}, 32'd0);
        check("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);

        send_lat(16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, "carry4");
        send_lat(16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, "ripple");
`ifdef PIPELINED_ADDER_SAT_EN
        send_lat(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h7FFF, 1'b0, 1'b1, "pos_ovf");
        send_lat(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h8000, 1'b1, 1'b1, "sub_ovf");
        send_lat(16'h8000, 16'hFFFF, 1'b0, 1'b0, 16'h8000, 1'b1, 1'b1, "neg_ovf");
`else
        send_lat(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, "pos_ovf");
        send_lat(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, "sub_ovf");
        send_lat(16'h8000, 16'hFFFF, 1'b0, 1'b0, 16'h7FFF, 1'b1, 1'b1, "neg_ovf");
`endif
        send_lat(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, "sub_borrow");
        send_lat(16'h0005, 16'h0003, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0, "sub_cin_ign");

        // Eight back-to-back ops with the consumer stalling in cycles 6..8.
        for (int i = 0; i < 8; i++) begin
            sa[i] = 16'($urandom);
            sb[i] = 16'($urandom);
            sc[i] = 1'($urandom);
            ss[i] = 1'($urandom);
        end
        sent = 0;
        base = n_out;
        for (int cyc = 0; cyc < 40 && !(sent == 8 && q.size() == 0); cyc++) begin
            bus.out_ready = !(cyc >= 6 && cyc <= 8);
            bus.in_valid  = (sent < 8);
            if (sent < 8) begin
                bus.a   = sa[sent];
                bus.b   = sb[sent];
                bus.cin = sc[sent];
                bus.sub = ss[sent];
            end
            #1;
            if (cyc >= 6 && cyc <= 8) begin
                check("stall_in_ready", {31'b0, bus.in_ready}, 32'd0);
                check("stall_out_valid", {31'b0, bus.out_valid}, 32'd1);
            end
            acc = bus.in_valid && bus.in_ready;
            tick();
            if (acc) sent++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        check("stream_sent", sent, 32'd8);
        check("stream_received", n_out - base, 32'd8);

        // Reset with three ops in flight and a fourth presented during reset.
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1;
            bus.a        = 16'($urandom);
            bus.b        = 16'($urandom);
            bus.cin      = 1'b0;
            bus.sub      = 1'b0;
            tick();
        end
        rst   = 1'b1;
        bus.a = 16'h1234;
        bus.b = 16'h1111;
        tick();
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        check("mid_rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        check("mid_rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
        check("mid_rst_sum", {16'b0, bus.sum}, 32'd0);
        for (int i = 0; i < 6; i++) begin
            check("no_stale", {31'b0, bus.out_valid}, 32'd0);
            tick();
        end
        m = model(16'h4321, 16'h0F0F, 1'b1, 1'b0);
        send_lat(16'h4321, 16'h0F0F, 1'b1, 1'b0, m.sum, m.cout, m.ovf, "post_rst");

        // Random traffic on both handshakes, then drain.
        base = n_out;
        sent = 0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            bus.in_valid  = 1'($urandom);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            bus.a         = 16'($urandom);
            bus.b         = 16'($urandom);
            bus.cin       = 1'($urandom);
            bus.sub       = 1'($urandom);
            #1;
            acc = bus.in_valid && bus.in_ready;
            tick();
            if (acc) sent++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int cyc = 0; cyc < 20 && q.size() != 0; cyc++) tick();
        check("random_received", n_out - base, sent);
        check("queue_drained", q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pipelined_adder.md
PIPELINED_ADDER -- requirements
Module: pipelined_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand and result width in bits; legal values are multiples of CHUNK, 4..64.
REQ-002 SHALL have parameter CHUNK, default 4, bits summed per pipeline stage; STAGES = WIDTH/CHUNK.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  operands present this cycle.
REQ-006 SHALL have port in_ready  output  1  block accepts operands this cycle.
REQ-007 SHALL have port a  input  WIDTH  operand A.
REQ-008 SHALL have port b  input  WIDTH  operand B.
REQ-009 SHALL have port cin  input  1  carry-in; used only when sub=0.
REQ-010 SHALL have port sub  input  1  0 = A+B+cin, 1 = A-B (A + ~B + 1).
REQ-011 SHALL have port out_valid  output  1  result present.
REQ-012 SHALL have port out_ready  input  1  consumer accepts result.
REQ-013 SHALL have port sum  output  WIDTH  result.
REQ-014 SHALL have port cout  output  1  carry out of MSB (for sub: 1 = no borrow).
REQ-015 SHALL have port ovf  output  1  two's-complement signed overflow of the operation.

Function
REQ-016 SHALL compute one CHUNK-bit slice per stage, LSB slice in stage 1, propagating the registered carry between stages; unprocessed operand slices and finished sum slices skewed through registers.
REQ-017 SHALL present the result STAGES cycles after acceptance when not stalled (default: 4).
REQ-018 Transfer in SHALL occur on a cycle with in_valid && in_ready; transfer out on out_valid && out_ready.
REQ-019 stall SHALL equal out_valid && !out_ready; in_ready SHALL equal !stall (combinational).
REQ-020 During stall all stage registers, valid bits, and sum/cout/ovf SHALL hold unchanged.
REQ-021 When not stalled each stage SHALL advance; a bubble (in_valid=0) SHALL propagate as a cleared valid bit.
REQ-022 SHALL sustain one operation per cycle with no bubbles while out_ready=1.
REQ-023 sum, cout, ovf SHALL be stable while out_valid=1 and out_ready=0.
REQ-024 ovf SHALL be (A[MSB]==B'[MSB]) && (sum[MSB]!=A[MSB]), where B' is the effective addend (~B for sub).
REQ-025 Results SHALL exit in acceptance order; no reordering, no drops.

Reset
REQ-026 While rst=1 at a clock edge, all stage valid bits, out_valid, sum, cout, ovf SHALL become 0.
REQ-027 Reset mid-operation SHALL discard all in-flight operations; in_ready SHALL be 1 the cycle after reset.
REQ-028 Operands presented in a cycle with rst=1 SHALL NOT be accepted.

Configuration
REQ-029 Macro PIPELINED_ADDER_SAT_EN, when defined, SHALL make sum saturate on signed overflow: positive overflow -> 0111..1, negative -> 1000..0; ovf still reports the overflow, cout unchanged.
REQ-030 Without PIPELINED_ADDER_SAT_EN, sum SHALL be the wrapped modulo-2^WIDTH result.

Verification (WIDTH=16, CHUNK=4)
REQ-031 a=0x00FF, b=0x0001, cin=0, sub=0, out_ready=1 -> 4 cycles later sum=0x0100, cout=0, ovf=0.
REQ-032 a=0xFFFF, b=0x0000, cin=1 -> sum=0x0000, cout=1, ovf=0 (full-width carry ripple across all stages).
REQ-033 a=0x7FFF, b=0x0001, sub=0 -> ovf=1; sum=0x8000 without macro, 0x7FFF with PIPELINED_ADDER_SAT_EN.
REQ-034 a=0x0005, b=0x0007, sub=1 -> sum=0xFFFE, cout=0, ovf=0; a=0x8000, b=0x0001, sub=1 -> ovf=1, sum=0x7FFF.
REQ-035 Stream 8 back-to-back ops, hold out_ready=0 for 3 cycles mid-stream -> in_ready=0 during stall, outputs frozen, all 8 results in order, none lost or duplicated.
REQ-036 Assert rst for 1 cycle with 3 ops in flight -> out_valid=0 next cycle, no stale result ever appears, new op completes 4 cycles later.
